// File: rtl/rv_uart_pkg.sv
// Register map, STATUS bit positions and serial FSM states for the Wishbone UART.
// Purely declarative: no latency or backpressure of its own.
package rv_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;
  localparam int ST_TX_BUSY    = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/rv_uart_fifo.sv
// Single-clock FIFO, 2**DEPTH_BITS entries; head visible combinationally (0-cycle read).
// Push to a full FIFO is dropped unless a pop happens in the same cycle; empty pop keeps last data.
module rv_uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  import rv_uart_pkg::*;

  localparam int                  DEPTH    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] CNT_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic [WIDTH-1:0]      last_dat;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign pop_dat = empty ? last_dat : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_dat <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        last_dat <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rv_wb_uart.sv
// Wishbone-mapped 8N1 UART: ack one cycle after hit, forced idle cycle after each ack, full TX pushes dropped.
// RX path (synchroniser, FSM, FIFO) is built only when RV_UART_RX_EN is defined.
module rv_wb_uart #(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int          FIFO_DEPTH_BITS = 2,
  parameter logic [15:0] DIV_RESET       = 16'd433
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  output logic        o_wb_ack,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_irq
);
  import rv_uart_pkg::*;

  logic        hit;
  logic [1:0]  req_reg;
  logic        req_we;
  logic [15:0] req_dat;
  logic [1:0]  req_sel;
  logic [19:0] wb_unused;

  logic [15:0] div_q;
  logic [1:0]  irq_en;
  logic        tx_push, rx_pop, rd_status, wr_div, wr_irq;
  logic        tx_full, tx_empty, tx_pop, tx_busy;
  logic [7:0]  tx_pop_dat;
  logic        rx_valid, rx_overrun, frame_err;
  logic [7:0]  rx_byte;
  logic [5:0]  status;
  logic [31:0] rd_dat;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;

  assign hit = i_wb_cyc & i_wb_stb & (i_wb_adr[31:4] == BASE_ADDR[31:4]) & ~o_wb_ack;
  assign wb_unused = {i_wb_adr[1:0], i_wb_dat[31:16], i_wb_sel[3:2]};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_wb_ack <= 1'b0;
      req_reg  <= '0;
      req_we   <= 1'b0;
      req_dat  <= '0;
      req_sel  <= '0;
    end else begin
      o_wb_ack <= hit;
      if (hit) begin
        req_reg <= i_wb_adr[3:2];
        req_we  <= i_wb_we;
        req_dat <= i_wb_dat[15:0];
        req_sel <= i_wb_sel[1:0];
      end
    end
  end

  // All register side effects happen in the ack cycle from the request captured at hit.
  assign tx_push   = o_wb_ack &  req_we & (req_reg == REG_DATA);
  assign rx_pop    = o_wb_ack & ~req_we & (req_reg == REG_DATA);
  assign rd_status = o_wb_ack & ~req_we & (req_reg == REG_STATUS);
  assign wr_div    = o_wb_ack &  req_we & (req_reg == REG_DIV) & req_sel[0];
  assign wr_irq    = o_wb_ack &  req_we & (req_reg == REG_IRQ_EN) & req_sel[0];

  assign status = {tx_busy, frame_err, rx_overrun, rx_valid, tx_empty, tx_full};

  always_comb begin
    rd_dat = '0;
    if (o_wb_ack && !req_we) begin
      case (req_reg)
        REG_DATA:   rd_dat = {23'b0, rx_valid, rx_byte};
        REG_STATUS: rd_dat = {26'b0, status};
        REG_DIV:    rd_dat = {16'b0, div_q};
        default:    rd_dat = {30'b0, irq_en};
      endcase
    end
  end
  assign o_wb_dat = rd_dat;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      div_q  <= DIV_RESET;
      irq_en <= '0;
      o_irq  <= 1'b0;
    end else begin
      if (wr_div) begin
        div_q[7:0] <= req_dat[7:0];
        if (req_sel[1]) div_q[15:8] <= req_dat[15:8];
      end
      if (wr_irq) irq_en <= req_dat[1:0];
      o_irq <= (irq_en[0] & rx_valid) | (irq_en[1] & tx_empty & ~tx_busy);
    end
  end

  rv_uart_fifo #(.WIDTH(8), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_tx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (tx_push),
    .push_dat  (req_dat[7:0]),
    .pop       (tx_pop),
    .pop_dat   (tx_pop_dat),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign tx_pop  = (tx_state == TX_IDLE) & ~tx_empty;
  assign tx_busy = (tx_state != TX_IDLE);

  // The bit counter reloads from DIV at every bit start so DIV edits only hit later bits.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      tx_state <= TX_IDLE;
      o_tx     <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_state <= TX_START;
          o_tx     <= 1'b0;
          tx_cnt   <= div_q;
          tx_shift <= tx_pop_dat;
        end
        TX_START: if (tx_cnt == 16'd0) begin
          tx_state <= TX_DATA;
          o_tx     <= tx_shift[0];
          tx_cnt   <= div_q;
          tx_idx   <= '0;
        end else tx_cnt <= tx_cnt - 16'd1;
        TX_DATA: if (tx_cnt == 16'd0) begin
          tx_cnt <= div_q;
          if (tx_idx == 3'd7) begin
            tx_state <= TX_STOP;
            o_tx     <= 1'b1;
          end else begin
            tx_idx   <= tx_idx + 3'd1;
            o_tx     <= tx_shift[1];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end else tx_cnt <= tx_cnt - 16'd1;
        TX_STOP: if (tx_cnt == 16'd0) tx_state <= TX_IDLE;
                 else tx_cnt <= tx_cnt - 16'd1;
      endcase
    end
  end

`ifdef RV_UART_RX_EN
  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_full, rx_empty, rx_push;

  assign rx_push  = (rx_state == RX_STOP) & (rx_cnt == 16'd0) & rx_s2 & ~rx_full;
  assign rx_valid = ~rx_empty;

  rv_uart_fifo #(.WIDTH(8), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_rx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (rx_push),
    .push_dat  (rx_shift),
    .pop       (rx_pop),
    .pop_dat   (rx_byte),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_state   <= RX_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rd_status) begin
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: if (rx_s3 && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt   <= div_q >> 1;
        end
        RX_START: if (rx_cnt == 16'd0) begin
          if (!rx_s2) begin
            rx_state <= RX_DATA;
            rx_cnt   <= div_q;
            rx_idx   <= '0;
          end else rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt - 16'd1;
        RX_DATA: if (rx_cnt == 16'd0) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_cnt   <= div_q;
          if (rx_idx == 3'd7) rx_state <= RX_STOP;
          else rx_idx <= rx_idx + 3'd1;
        end else rx_cnt <= rx_cnt - 16'd1;
        RX_STOP: if (rx_cnt == 16'd0) begin
          rx_state <= RX_IDLE;
          if (!rx_s2) frame_err <= 1'b1;
          else if (rx_full) rx_overrun <= 1'b1;
        end else rx_cnt <= rx_cnt - 16'd1;
      endcase
    end
  end
`else
  logic [1:0] rx_unused;
  assign rx_unused  = {i_rx, rx_pop};
  assign rx_valid   = 1'b0;
  assign rx_byte    = '0;
  assign rx_overrun = 1'b0;
  assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rv_wb_uart.sv
// Bench for rv_wb_uart: register vector table, serial frame reference, FIFO overflow, reset abort.
module tb_rv_wb_uart;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [15:0] DIV_RST = 16'd433;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] i_wb_adr = '0;
  logic [31:0] i_wb_dat = '0;
  logic [31:0] o_wb_dat;
  logic        i_wb_we = 1'b0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        o_wb_ack;
  logic        i_rx = 1'b1;
  logic        o_tx;
  logic        o_irq;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  rv_wb_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH_BITS(2), .DIV_RESET(DIV_RST)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .o_wb_dat(o_wb_dat), .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel), .i_wb_stb(i_wb_stb),
    .i_wb_cyc(i_wb_cyc), .o_wb_ack(o_wb_ack), .i_rx(i_rx), .o_tx(o_tx), .o_irq(o_irq)
  );

  typedef struct {
    logic [3:0]  off;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  // One Wishbone access; the ack must come exactly one cycle after the strobe is presented.
  task automatic wb(input logic [3:0] off, input logic we, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rdat);
    int lat;
    i_wb_adr = BASE + 32'(off);
    i_wb_we  = we;
    i_wb_dat = dat;
    i_wb_sel = sel;
    i_wb_stb = 1'b1;
    i_wb_cyc = 1'b1;
    lat = 0;
    do begin @(posedge i_clk); #1; lat++; end while (!o_wb_ack && lat < 20);
    rdat = o_wb_dat;
    check($sformatf("ack_latency@%0h", off), lat, 1);
    i_wb_stb = 1'b0;
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    tick(1);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    wb(off, 1'b1, dat, sel, r);
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] r);
    wb(off, 1'b0, 32'h0, 4'hF, r);
  endtask

  // Reference 8N1 waveform: start 0, data LSB first, stop 1, each bit div+1 clocks.
  task automatic check_frame(input logic [7:0] b, input int div, input string name);
    int n, bad, per;
    logic exp_bit;
    n = 0;
    while (o_tx !== 1'b0 && n < 400) begin @(posedge i_clk); #1; n++; end
    check({name, "_start_seen"}, (o_tx === 1'b0), 1);
    if (o_tx !== 1'b0) return;
    per = div + 1;
    bad = 0;
    for (int c = 0; c < 10 * per; c++) begin
      int k;
      k = c / per;
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      if (o_tx !== exp_bit) bad++;
      if (c != 10 * per - 1) begin @(posedge i_clk); #1; end
    end
    check({name, "_bad_cycles"}, bad, 0);
  endtask

`ifdef RV_UART_RX_EN
  task automatic rx_drive(input logic [7:0] b, input int div, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx = fr[i];
      tick(div + 1);
    end
    i_rx = 1'b1;
    tick(2 * (div + 1));
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] r;
    logic [31:0] d;
    logic [3:0]  s;
    logic [15:0] div_m;
    logic [7:0]  b;
    int          dv, acks, consec, datbad, lows, n;
    logic        prev;

    tick(3);
    check("rst_tx", o_tx, 1);
    check("rst_ack", o_wb_ack, 0);
    check("rst_dat", o_wb_dat, 0);
    check("rst_irq", o_irq, 0);
    i_reset_n = 1'b1;
    tick(2);

    vecs.push_back('{4'h4, 1'b0, 32'h0,        4'hF, 32'h0000_0002});
    vecs.push_back('{4'h8, 1'b0, 32'h0,        4'hF, 32'h0000_01B1});
    vecs.push_back('{4'hC, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
    vecs.push_back('{4'h0, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
    vecs.push_back('{4'h8, 1'b1, 32'h0000_1234, 4'h1, 32'h0000_0000});
    vecs.push_back('{4'h8, 1'b0, 32'h0,        4'hF, 32'h0000_0134});
    vecs.push_back('{4'h8, 1'b1, 32'h0000_ABCD, 4'h2, 32'h0000_0000});
    vecs.push_back('{4'h8, 1'b0, 32'h0,        4'hF, 32'h0000_0134});
    vecs.push_back('{4'h8, 1'b1, 32'hFFFF_5678, 4'h3, 32'h0000_0000});
    vecs.push_back('{4'h8, 1'b0, 32'h0,        4'hF, 32'h0000_5678});
    vecs.push_back('{4'hC, 1'b1, 32'h0000_0003, 4'h0, 32'h0000_0000});
    vecs.push_back('{4'hC, 1'b0, 32'h0,        4'hF, 32'h0000_0000});
    vecs.push_back('{4'hC, 1'b1, 32'hFFFF_FFFD, 4'h1, 32'h0000_0000});
    vecs.push_back('{4'hC, 1'b0, 32'h0,        4'hF, 32'h0000_0001});
    vecs.push_back('{4'hC, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000});
    vecs.push_back('{4'h4, 1'b1, 32'h0000_00FF, 4'hF, 32'h0000_0000});
    vecs.push_back('{4'h4, 1'b0, 32'h0,        4'hF, 32'h0000_0002});
    vecs.push_back('{4'h8, 1'b1, 32'h0000_0003, 4'hF, 32'h0000_0000});
    vecs.push_back('{4'h8, 1'b0, 32'h0,        4'hF, 32'h0000_0003});
    foreach (vecs[i]) begin
      wb(vecs[i].off, vecs[i].we, vecs[i].dat, vecs[i].sel, r);
      check($sformatf("vec%0d_rdat", i), r, vecs[i].exp);
    end

    // Continuous strobe: acks must alternate, read data zero outside ack.
    i_wb_adr = BASE + 32'h4;
    i_wb_stb = 1'b1;
    i_wb_cyc = 1'b1;
    acks = 0; consec = 0; datbad = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (o_wb_ack) acks++;
      if (o_wb_ack && prev) consec++;
      if (!o_wb_ack && o_wb_dat != 32'h0) datbad++;
      prev = o_wb_ack;
    end
    i_wb_stb = 1'b0;
    i_wb_cyc = 1'b0;
    tick(1);
    check("b2b_acks", acks, 10);
    check("b2b_consecutive", consec, 0);
    check("b2b_idle_dat", datbad, 0);

    i_wb_adr = BASE + 32'h10;
    i_wb_stb = 1'b1;
    i_wb_cyc = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin tick(1); if (o_wb_ack) acks++; end
    i_wb_stb = 1'b0;
    i_wb_cyc = 1'b0;
    tick(1);
    check("outside_window_acks", acks, 0);

    wr(4'h0, 32'h55, 4'hF);
    check_frame(8'h55, 3, "frame55");

    // Interrupt on TX idle and empty.
    tick(3);
    check("irq_off", o_irq, 0);
    wr(4'hC, 32'h2, 4'h1);
    tick(2);
    check("irq_tx_idle", o_irq, 1);
    wr(4'h0, 32'h3C, 4'hF);
    fork
      check_frame(8'h3C, 3, "frame3C");
      begin tick(5); check("irq_tx_busy", o_irq, 0); end
    join
    tick(3);
    check("irq_after_frame", o_irq, 1);
    wr(4'hC, 32'h0, 4'hF);
    tick(2);
    check("irq_disabled", o_irq, 0);

    // Randomised DIV register writes against a byte-select model.
    div_m = 16'd3;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      wr(4'h8, d, s);
      if (s[0]) begin
        div_m[7:0] = d[7:0];
        if (s[1]) div_m[15:8] = d[15:8];
      end
      rd(4'h8, r);
      check($sformatf("rand_div%0d", i), r, {16'h0, div_m});
    end

    // Randomised frames at random bit periods.
    for (int i = 0; i < 6; i++) begin
      dv = $urandom_range(1, 5);
      b  = 8'($urandom_range(0, 255));
      wr(4'h8, 32'(dv), 4'hF);
      wr(4'h0, {24'h0, b}, 4'hF);
      check_frame(b, dv, $sformatf("rand_frame%0d", i));
    end

    // Overflow: A in flight, B..E fill the FIFO, F is dropped.
    tick(3);
    wr(4'h8, 32'd3, 4'hF);
    wr(4'h0, 32'hA1, 4'hF);
    fork
      begin
        check_frame(8'hA1, 3, "ovf_A");
        check_frame(8'hB2, 3, "ovf_B");
        check_frame(8'hC3, 3, "ovf_C");
        check_frame(8'hD4, 3, "ovf_D");
        check_frame(8'hE5, 3, "ovf_E");
      end
      begin
        wr(4'h0, 32'hB2, 4'hF);
        wr(4'h0, 32'hC3, 4'hF);
        wr(4'h0, 32'hD4, 4'hF);
        wr(4'h0, 32'hE5, 4'hF);
        rd(4'h4, r);
        check("ovf_status_full", r, 32'h21);
        wr(4'h0, 32'hF6, 4'hF);
        rd(4'h4, r);
        check("ovf_status_still_full", r, 32'h21);
      end
    join
    lows = 0;
    for (int i = 0; i < 60; i++) begin tick(1); if (o_tx !== 1'b1) lows++; end
    check("ovf_no_sixth_frame", lows, 0);
    rd(4'h4, r);
    check("ovf_status_drained", r, 32'h02);

`ifdef RV_UART_RX_EN
    wr(4'h8, 32'd7, 4'hF);
    rx_drive(8'hA3, 7, 1'b1);
    rd(4'h4, r);
    check("rx_valid", (r >> 2) & 32'h1, 1);
    rd(4'h0, r);
    check("rx_data", r, 32'h1A3);
    rd(4'h0, r);
    check("rx_empty_valid", (r >> 8) & 32'h1, 0);
    rx_drive(8'h11, 7, 1'b0);
    rd(4'h4, r);
    check("frame_err_set", (r >> 4) & 32'h1, 1);
    rd(4'h4, r);
    check("frame_err_clear", (r >> 4) & 32'h1, 0);
`endif

    // Reset in the middle of a frame.
    wr(4'h8, 32'd20, 4'hF);
    wr(4'h0, 32'hF0, 4'hF);
    n = 0;
    while (o_tx !== 1'b0 && n < 100) begin tick(1); n++; end
    check("midrst_frame_started", (o_tx === 1'b0), 1);
    tick(50);
    i_reset_n = 1'b0;
    tick(1);
    check("midrst_tx", o_tx, 1);
    check("midrst_ack", o_wb_ack, 0);
    check("midrst_irq", o_irq, 0);
    tick(2);
    i_reset_n = 1'b1;
    tick(1);
    rd(4'h4, r);
    check("midrst_status", r, 32'h02);
    rd(4'h8, r);
    check("midrst_div", r, {16'h0, DIV_RST});
    lows = 0;
    for (int i = 0; i < 30; i++) begin tick(1); if (o_tx !== 1'b1) lows++; end
    check("midrst_line_idle", lows, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
